// File: rtl/cpu_defs_pkg.sv
// Shared decode definitions: widths, instruction field positions, immediate modes.
package cpu_defs;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned REG_CNT = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IMM_W   = 16;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 26;
  localparam int unsigned RS_HI  = 25;
  localparam int unsigned RS_LO  = 21;
  localparam int unsigned RD_HI  = 20;
  localparam int unsigned RD_LO  = 16;
  localparam int unsigned RT_HI  = 15;
  localparam int unsigned RT_LO  = 11;
  localparam int unsigned IMM_HI = 15;
  localparam int unsigned IMM_LO = 0;

  typedef enum logic [1:0] {
    IMM_SEXT = 2'b00,
    IMM_ZEXT = 2'b01,
    IMM_LUI  = 2'b10,
    IMM_BR   = 2'b11
  } imm_ext_e;

  // Write-back payload from the memory/write-back stage
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_t;

  // Branch mode drops the top two sign bits so the result stays 32 bits wide
  function automatic logic [DATA_W-1:0] imm_extend(input logic [IMM_W-1:0] i,
                                                   input imm_ext_e mode);
    logic [DATA_W-1:0] r;
    case (mode)
      IMM_ZEXT: r = {16'b0, i};
      IMM_LUI:  r = {i, 16'b0};
      IMM_BR:   r = {{14{i[IMM_W-1]}}, i, 2'b00};
      default:  r = {{16{i[IMM_W-1]}}, i};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decstage_if.sv
// Decode-stage bus: instruction in, write-back port, registered operands out.
interface decstage_if;
  import cpu_defs::*;

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               stall;
  logic               rf_b_sel;
  imm_ext_e           imm_ext;
  wb_t                wb;
  logic [DATA_W-1:0]  rfa;
  logic [DATA_W-1:0]  rfb;
  logic [DATA_W-1:0]  immed;
  logic               out_valid;

  modport master (
    output instr, instr_valid, stall, rf_b_sel, imm_ext, wb,
    input  rfa, rfb, immed, out_valid
  );

  modport slave (
    input  instr, instr_valid, stall, rf_b_sel, imm_ext, wb,
    output rfa, rfb, immed, out_valid
  );
endinterface

// File: rtl/decstage_regfile.sv
// 32x32 register file: two combinational read ports, one clocked write port, r0 reads zero.
module regfile
  import cpu_defs::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a_c,
  output logic [DATA_W-1:0] rdata_b_c
);

  logic [DATA_W-1:0] regs [REG_CNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(REG_CNT); i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a_c = (raddr_a == '0) ? '0 : regs[raddr_a];
    rdata_b_c = (raddr_b == '0) ? '0 : regs[raddr_b];
  end

endmodule

// File: rtl/decstage.sv
// Instruction decode stage: register read with write-back bypass, immediate extension,
// and a one-deep pipeline register feeding the ALU stage.
module decstage
  import cpu_defs::*;
(
  input  logic       clk,
  input  logic       rst_n,
  decstage_if.slave  bus
);

  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rd;
  logic [ADDR_W-1:0] rt;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] rf_a_c;
  logic [DATA_W-1:0] rf_b_c;
  logic [DATA_W-1:0] opa_c;
  logic [DATA_W-1:0] opb_c;
  logic [DATA_W-1:0] imm_c;
  logic              wb_live;
  logic [ADDR_W-1:0] cap_a;
  logic [ADDR_W-1:0] cap_b;

  always_comb begin
    rs      = bus.instr[RS_HI:RS_LO];
    rd      = bus.instr[RD_HI:RD_LO];
    rt      = bus.instr[RT_HI:RT_LO];
    addr_b  = bus.rf_b_sel ? rd : rt;
    wb_live = bus.wb.en && (bus.wb.addr != '0);
    imm_c   = imm_extend(bus.instr[IMM_HI:IMM_LO], bus.imm_ext);
  end

  regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (bus.wb.en),
    .waddr     (bus.wb.addr),
    .wdata     (bus.wb.data),
    .raddr_a   (rs),
    .raddr_b   (addr_b),
    .rdata_a_c (rf_a_c),
    .rdata_b_c (rf_b_c)
  );

  // Same-cycle write-to-read forwarding, independent per port
  always_comb begin
    opa_c = (wb_live && (bus.wb.addr == rs))     ? bus.wb.data : rf_a_c;
    opb_c = (wb_live && (bus.wb.addr == addr_b)) ? bus.wb.data : rf_b_c;
  end

  // While stalled, held operands track write-back to their captured source registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rfa       <= '0;
      bus.rfb       <= '0;
      bus.immed     <= '0;
      bus.out_valid <= 1'b0;
      cap_a         <= '0;
      cap_b         <= '0;
    end else if (!bus.stall) begin
      bus.rfa       <= opa_c;
      bus.rfb       <= opb_c;
      bus.immed     <= imm_c;
      bus.out_valid <= bus.instr_valid;
      cap_a         <= rs;
      cap_b         <= addr_b;
    end else begin
      if (wb_live && (bus.wb.addr == cap_a)) bus.rfa <= bus.wb.data;
      if (wb_live && (bus.wb.addr == cap_b)) bus.rfb <= bus.wb.data;
    end
  end

endmodule

// File: tb/tb_decstage.sv
// Directed self-checking bench for the decode stage.
module tb_decstage;
  import cpu_defs::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  decstage_if dif ();

  decstage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [4:0] rs, input logic [4:0] rd,
                                           input logic [15:0] imm);
    return {6'h00, rs, rd, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb_t w;
    w.en   = en;
    w.addr = addr;
    w.data = data;
    dif.wb = w;
  endtask

  task automatic idle();
    dif.instr       = '0;
    dif.instr_valid = 1'b0;
    dif.stall       = 1'b0;
    dif.rf_b_sel    = 1'b0;
    dif.imm_ext     = IMM_SEXT;
    set_wb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #12;
    checks++; if (dif.rfa !== 32'h0) begin errors++; $display("FAIL reset_rfa: got %h want %h", dif.rfa, 32'h0); end
    checks++; if (dif.rfb !== 32'h0) begin errors++; $display("FAIL reset_rfb: got %h want %h", dif.rfb, 32'h0); end
    checks++; if (dif.immed !== 32'h0) begin errors++; $display("FAIL reset_immed: got %h want %h", dif.immed, 32'h0); end
    checks++; if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dif.out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    set_wb(1'b1, 5'd3, 32'd12);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    dif.instr       = mk_instr(5'd3, 5'd0, 16'h000B);
    dif.instr_valid = 1'b1;
    dif.imm_ext     = IMM_SEXT;
    tick();
    checks++; if (dif.rfa !== 32'd12) begin errors++; $display("FAIL basic_rfa: got %h want %h", dif.rfa, 32'd12); end
    checks++; if (dif.immed !== 32'd11) begin errors++; $display("FAIL basic_immed: got %h want %h", dif.immed, 32'd11); end
    checks++; if (dif.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", dif.out_valid); end
  endtask

  task automatic test_imm_modes();
    imm_ext_e    modes [4] = '{IMM_SEXT, IMM_ZEXT, IMM_LUI, IMM_BR};
    logic [31:0] exp   [4] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004};
    dif.instr       = mk_instr(5'd0, 5'd0, 16'h8001);
    dif.instr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dif.imm_ext = modes[k];
      tick();
      checks++;
      if (dif.immed !== exp[k]) begin
        errors++;
        $display("FAIL imm_mode%0d: got %h want %h", k, dif.immed, exp[k]);
      end
    end
    dif.imm_ext = IMM_SEXT;
  endtask

  task automatic test_bypass();
    // rt=7 lives in imm[15:11]
    set_wb(1'b1, 5'd7, 32'hDEADBEEF);
    dif.instr       = mk_instr(5'd0, 5'd0, 16'h3800);
    dif.rf_b_sel    = 1'b0;
    dif.instr_valid = 1'b1;
    tick();
    checks++; if (dif.rfb !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_b: got %h want %h", dif.rfb, 32'hDEADBEEF); end
    set_wb(1'b1, 5'd0, 32'h11111111);
    dif.instr = mk_instr(5'd0, 5'd0, 16'h0000);
    tick();
    checks++; if (dif.rfa !== 32'h0) begin errors++; $display("FAIL bypass_r0: got %h want %h", dif.rfa, 32'h0); end
    set_wb(1'b0, 5'd0, 32'h0);
    tick();
    checks++; if (dif.rfa !== 32'h0) begin errors++; $display("FAIL r0_write_ignored: got %h want %h", dif.rfa, 32'h0); end
    // stored (non-bypassed) read of r7
    dif.instr = mk_instr(5'd7, 5'd0, 16'h0000);
    tick();
    checks++; if (dif.rfa !== 32'hDEADBEEF) begin errors++; $display("FAIL stored_r7: got %h want %h", dif.rfa, 32'hDEADBEEF); end
  endtask

  task automatic test_stall();
    set_wb(1'b1, 5'd4, 32'h10);
    dif.instr_valid = 1'b0;
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    dif.instr       = mk_instr(5'd4, 5'd6, 16'h0042);
    dif.rf_b_sel    = 1'b1;
    dif.instr_valid = 1'b1;
    tick();
    checks++; if (dif.rfa !== 32'h10) begin errors++; $display("FAIL stall_pre_rfa: got %h want %h", dif.rfa, 32'h10); end
    checks++; if (dif.rfb !== 32'h0) begin errors++; $display("FAIL stall_pre_rfb: got %h want %h", dif.rfb, 32'h0); end
    dif.stall = 1'b1;
    set_wb(1'b1, 5'd4, 32'h55);
    dif.instr = mk_instr(5'd3, 5'd9, 16'h7777);
    tick();
    checks++; if (dif.rfa !== 32'h55) begin errors++; $display("FAIL stall_upd_rfa: got %h want %h", dif.rfa, 32'h55); end
    checks++; if (dif.immed !== 32'h42) begin errors++; $display("FAIL stall_hold_immed: got %h want %h", dif.immed, 32'h42); end
    checks++; if (dif.out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid: got %b want 1", dif.out_valid); end
    set_wb(1'b1, 5'd6, 32'hAB);
    tick();
    checks++; if (dif.rfb !== 32'hAB) begin errors++; $display("FAIL stall_upd_rfb: got %h want %h", dif.rfb, 32'hAB); end
    checks++; if (dif.rfa !== 32'h55) begin errors++; $display("FAIL stall_keep_rfa: got %h want %h", dif.rfa, 32'h55); end
    set_wb(1'b1, 5'd3, 32'h999);
    dif.instr       = mk_instr(5'd3, 5'd3, 16'hFFFF);
    dif.instr_valid = 1'b0;
    tick();
    checks++; if (dif.rfa !== 32'h55) begin errors++; $display("FAIL stall_ign_rfa: got %h want %h", dif.rfa, 32'h55); end
    checks++; if (dif.rfb !== 32'hAB) begin errors++; $display("FAIL stall_ign_rfb: got %h want %h", dif.rfb, 32'hAB); end
    checks++; if (dif.immed !== 32'h42) begin errors++; $display("FAIL stall_ign_immed: got %h want %h", dif.immed, 32'h42); end
    checks++; if (dif.out_valid !== 1'b1) begin errors++; $display("FAIL stall_ign_valid: got %b want 1", dif.out_valid); end
    dif.stall = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);
    dif.rf_b_sel = 1'b0;
  endtask

  task automatic test_b_sel();
    dif.instr_valid = 1'b0;
    set_wb(1'b1, 5'd9, 32'h1234);
    tick();
    set_wb(1'b1, 5'd2, 32'h99);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    dif.instr       = mk_instr(5'd0, 5'd9, 16'h1000);
    dif.rf_b_sel    = 1'b1;
    dif.instr_valid = 1'b1;
    tick();
    checks++; if (dif.rfb !== 32'h1234) begin errors++; $display("FAIL bsel_rd: got %h want %h", dif.rfb, 32'h1234); end
    dif.rf_b_sel = 1'b0;
    tick();
    checks++; if (dif.rfb !== 32'h99) begin errors++; $display("FAIL bsel_rt: got %h want %h", dif.rfb, 32'h99); end
    dif.instr_valid = 1'b0;
    tick();
    checks++; if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL invalid_bubble: got %b want 0", dif.out_valid); end
    checks++; if (dif.immed !== 32'h1000) begin errors++; $display("FAIL bubble_immed: got %h want %h", dif.immed, 32'h1000); end
  endtask

  task automatic test_midrun_reset();
    set_wb(1'b1, 5'd5, 32'h5A5A);
    dif.instr_valid = 1'b0;
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    dif.instr       = mk_instr(5'd5, 5'd5, 16'h00FF);
    dif.instr_valid = 1'b1;
    tick();
    checks++; if (dif.rfa !== 32'h5A5A) begin errors++; $display("FAIL pre_reset_rfa: got %h want %h", dif.rfa, 32'h5A5A); end
    dif.stall = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (dif.rfa !== 32'h0) begin errors++; $display("FAIL async_rst_rfa: got %h want %h", dif.rfa, 32'h0); end
    checks++; if (dif.rfb !== 32'h0) begin errors++; $display("FAIL async_rst_rfb: got %h want %h", dif.rfb, 32'h0); end
    checks++; if (dif.immed !== 32'h0) begin errors++; $display("FAIL async_rst_immed: got %h want %h", dif.immed, 32'h0); end
    checks++; if (dif.out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b want 0", dif.out_valid); end
    @(negedge clk);
    rst_n     = 1'b1;
    dif.stall = 1'b0;
    tick();
    checks++; if (dif.rfa !== 32'h0) begin errors++; $display("FAIL post_rst_r5: got %h want %h", dif.rfa, 32'h0); end
    checks++; if (dif.out_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid: got %b want 1", dif.out_valid); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_imm_modes();
    test_bypass();
    test_stall();
    test_b_sel();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decstage.md
Name: decstage

Overview:
- Instruction-decode stage sitting directly upstream of alustage.
- Splits the 32-bit instruction, reads two operands from a 32x32 register file and extends the 16-bit immediate.
- Registers rfa/rfb/immed into a one-deep pipeline register that drives alustage's rfa, rfb and immed inputs.
- Accepts the write-back port from the downstream memory/write-back stage, with write-to-read bypass.

Parameters:
- DATA_W, 32, operand and register width.
- REG_CNT, 32, number of architectural registers; r0 is hardwired to zero.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Instr  input  32  instruction word: opcode[31:26], rs[25:21], rd[20:16], rt[15:11], immed[15:0].
- Instr_valid  input  1  Instr holds a real instruction this cycle.
- Stall  input  1  downstream not accepting; hold the pipeline register.
- RF_B_sel  input  1  0: read port B addressed by rt; 1: by rd.
- ImmExt  input  2  00 sign-extend, 01 zero-fill, 10 shift-left-16 (lui), 11 sign-extend then <<2 (branch offset).
- Wb_en  input  1  register-file write enable.
- Wb_addr  input  5  write address.
- Wb_data  input  32  write data.
- rfa  output  32  registered operand A, i.e. RF[rs].
- rfb  output  32  registered operand B, i.e. RF[rt] or RF[rd].
- immed  output  32  registered extended immediate.
- Out_valid  output  1  rfa/rfb/immed hold a valid decoded instruction.

Behaviour:
- Reset (Rst_n low, async):
  - all 32 registers cleared to 0.
  - rfa=0, rfb=0, immed=0, Out_valid=0.
  - captured source addresses cleared to 0.
  - Reset mid-stall discards the held instruction.
- Register file:
  - write occurs on the rising edge when Wb_en=1 and Wb_addr!=0.
  - writes to r0 are ignored; reads of r0 always return 0.
  - reads are combinational.
- Bypass:
  - if Wb_en=1, Wb_addr!=0 and Wb_addr equals a read address in the same cycle, that read returns Wb_data instead of the stale value.
  - applies independently to ports A and B.
- Pipeline register, latency 1 cycle:
  - When Stall=0, at the edge: rfa, rfb and immed load the decoded values; Out_valid loads Instr_valid; rs and the selected B address are captured.
  - When Instr_valid=0 and Stall=0: Out_valid becomes 0, and rfa/rfb/immed still load; the data is don't-care but deterministic.
- Stall=1:
  - rfa, rfb, immed and Out_valid hold, and Instr is ignored.
  - Write-back still proceeds.
  - If Wb_en=1 and Wb_addr!=0 equals the captured A address, rfa loads Wb_data at that edge; the same rule applies to rfb with the captured B address. This prevents stale held operands.
- Immediate extension, from Instr[15:0]:
  - 00: {{16{i[15]}}, i}
  - 01: {16'b0, i}
  - 10: {i, 16'b0}
  - 11: sign-extend then shift left 2; the upper bits are truncated to 32.
  - Unsigned mux, no overflow flag.
- Simultaneous Stall=1 and Instr_valid=1: the instruction is not consumed. Upstream must re-present it; Instr_valid is not a handshake acceptance.
- No internal state machine beyond the valid bit. Behaviour is purely register-file plus pipeline-register sequencing.

Decomposition:
- Shared package/header `cpu_defs`:
  - ImmExt encodings IMM_SEXT, IMM_ZEXT, IMM_LUI, IMM_BR.
  - Instruction field bit positions.
  - DATA_W.
- One sub-module, `regfile`: 2 async read ports, 1 sync write port, async active-low clear, r0 forced to zero.
- Bypass and the pipeline register live in decstage.

Test Plan:
- Reset with Rst_n=0 mid-run -> rfa=rfb=immed=0 and Out_valid=0 immediately, without waiting for a clock edge; subsequent reads of r5 return 0.
- Write Wb_addr=3, Wb_data=12 (Wb_en=1); next cycle Instr rs=3, immed=0x000B, ImmExt=00 -> one cycle later rfa=12, immed=11, Out_valid=1. This gives alustage rfa=12, immed=11.
- Immediate modes on i=0x8001: 00 -> 0xFFFF8001; 01 -> 0x00008001; 10 -> 0x80010000; 11 -> 0xFFFE0004.
- Same-cycle bypass: Wb_addr=7, Wb_data=0xDEADBEEF while Instr rt=7 with RF_B_sel=0 -> rfb=0xDEADBEEF next cycle. Writing Wb_addr=0 with rs=0 -> rfa=0.
- Stall hold plus update: with rfa captured from rs=4, assert Stall=1 and write r4=0x55 -> rfa becomes 0x55 and immed is unchanged. Changing Instr while stalled has no effect on the outputs.
- RF_B_sel=1 with rd=9 holding 0x1234 and rt=2 holding 0x99 -> rfb=0x1234. Instr_valid=0 with Stall=0 -> Out_valid=0 next cycle.
